// File: rtl/vc_rr_src_mux.sv
// vc_rr_src_mux: round-robin merge of p_nreqs val/rdy sources into one sink.
// Optional clocked checks when VC_RR_SRC_MUX_ASSERT_EN is defined.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_val/in_rdy/in_msg  per-requester handshake, payload i at [i*W +: W]
//   in_done               per-source done flags
//   out_val/out_rdy       registered sink handshake
//   out_msg               {winner id, payload}, registered
//   all_done              all sources done and output stage empty
module vc_rr_src_mux #(
   parameter  int p_nreqs     = 4,
   parameter  int p_msg_nbits = 32,
   parameter  int p_max_burst = 4,
   localparam int c_id_nbits  = $clog2(p_nreqs)
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [p_nreqs-1:0]                in_val,
   output logic [p_nreqs-1:0]                in_rdy,
   input  logic [p_nreqs*p_msg_nbits-1:0]    in_msg,
   input  logic [p_nreqs-1:0]                in_done,
   output logic                              out_val,
   input  logic                              out_rdy,
   output logic [c_id_nbits+p_msg_nbits-1:0] out_msg,
   output logic                              all_done
);

   localparam int c_bc_nbits = $clog2(p_max_burst + 1);

   typedef enum logic {ARB, LOCK} state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [c_id_nbits-1:0]   ptr;
   logic [c_id_nbits-1:0]   ptr_nx;
   logic [c_id_nbits-1:0]   owner;
   logic [c_id_nbits-1:0]   owner_nx;
   logic [c_bc_nbits-1:0]   burst_cnt;
   logic [c_bc_nbits-1:0]   burst_nx;
   logic [c_id_nbits-1:0]   grant;
   logic [c_id_nbits-1:0]   cand;
   logic [p_msg_nbits-1:0]  sel_msg;
   logic                    grant_valid;
   logic                    can_accept;
   logic                    fire_in;
   logic                    out_fire;
   logic                    live;
   int                      idx;

   function automatic logic [c_id_nbits-1:0] next_id(
      input logic [c_id_nbits-1:0] id
   );
      if (id == c_id_nbits'(p_nreqs - 1)) return '0;
      return id + c_id_nbits'(1);
   endfunction

   // Scan requesters starting at ptr, wrapping modulo p_nreqs.
   always_comb begin
      grant       = owner;
      grant_valid = 1'b0;
      cand        = '0;
      idx         = 0;
      if (state == LOCK) begin
         grant_valid = in_val[owner];
      end else begin
         for (int k = 0; k < p_nreqs; k++) begin
            idx = int'(ptr) + k;
            if (idx >= p_nreqs) idx = idx - p_nreqs;
            cand = c_id_nbits'(idx);
            if (!grant_valid && in_val[cand]) begin
               grant       = cand;
               grant_valid = 1'b1;
            end
         end
      end
   end

   // live holds off the first edge after reset release.
   assign can_accept = live && (!out_val || out_rdy);
   assign fire_in    = grant_valid && can_accept;
   assign out_fire   = out_val && out_rdy;

   always_comb begin
      in_rdy  = '0;
      sel_msg = '0;
      for (int i = 0; i < p_nreqs; i++) begin
         in_rdy[i] = fire_in && (grant == c_id_nbits'(i));
         if (grant == c_id_nbits'(i))
            sel_msg = in_msg[i*p_msg_nbits +: p_msg_nbits];
      end
   end

   // Arbitration state only moves when the output can take a message.
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      owner_nx = owner;
      burst_nx = burst_cnt;
      if (can_accept) begin
         unique case (state)
            ARB: begin
               if (fire_in) begin
                  owner_nx = grant;
                  burst_nx = c_bc_nbits'(1);
                  if (p_max_burst == 1) ptr_nx = next_id(grant);
                  else                  state_nx = LOCK;
               end
            end
            LOCK: begin
               if (!in_val[owner]) begin
                  ptr_nx   = next_id(owner);
                  state_nx = ARB;
               end else begin
                  burst_nx = burst_cnt + c_bc_nbits'(1);
                  if (burst_cnt == c_bc_nbits'(p_max_burst - 1)) begin
                     ptr_nx   = next_id(owner);
                     state_nx = ARB;
                  end
               end
            end
            default: state_nx = ARB;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ARB;
         ptr       <= '0;
         owner     <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         owner     <= owner_nx;
         burst_cnt <= burst_nx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         live     <= 1'b0;
         out_val  <= 1'b0;
         out_msg  <= '0;
         all_done <= 1'b0;
      end else begin
         live <= 1'b1;
         if (fire_in) begin
            out_val <= 1'b1;
            out_msg <= {grant, sel_msg};
         end else if (out_fire) begin
            out_val <= 1'b0;
         end
         all_done <= live && (&in_done) && !out_val && !fire_in;
      end
   end

`ifdef VC_RR_SRC_MUX_ASSERT_EN
   logic                              chk_stall;
   logic [c_id_nbits+p_msg_nbits-1:0] chk_msg;

   always @(posedge clk) begin
      if (reset_n) begin
         if (!$onehot0(in_rdy)) begin
            $display("vc_rr_src_mux error: in_rdy not onehot0");
            $finish;
         end
         if ($isunknown(in_val) || $isunknown(out_rdy)) begin
            $display("vc_rr_src_mux error: X on in_val/out_rdy");
            $finish;
         end
         if (chk_stall && (out_msg != chk_msg)) begin
            $display("vc_rr_src_mux error: out_msg changed in stall");
            $finish;
         end
         if (int'(burst_cnt) > p_max_burst) begin
            $display("vc_rr_src_mux error: burst_cnt overflow");
            $finish;
         end
      end
      chk_stall <= reset_n && out_val && !out_rdy;
      chk_msg   <= out_msg;
   end
`else
   // No checking logic in this build.
`endif

endmodule

// File: tb/tb_vc_rr_src_mux.sv
// tb_vc_rr_src_mux: directed + random bench with a lease-based
// arbitration model and per-cycle output comparison.
module tb_vc_rr_src_mux;

   localparam int N   = 4;
   localparam int W   = 32;
   localparam int B   = 2;
   localparam int IDW = 2;
   localparam int OW  = IDW + W;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [N-1:0]  in_val = '0;
   logic [N-1:0]  in_rdy;
   logic [N*W-1:0] in_msg = '0;
   logic [N-1:0]  in_done = '0;
   logic          out_val;
   logic          out_rdy = 1'b1;
   logic [OW-1:0] out_msg;
   logic          all_done;

   always #5 clk = ~clk;

   vc_rr_src_mux #(
      .p_nreqs    (N),
      .p_msg_nbits(W),
      .p_max_burst(B)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .in_val  (in_val),
      .in_rdy  (in_rdy),
      .in_msg  (in_msg),
      .in_done (in_done),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out_msg (out_msg),
      .all_done(all_done)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] pay(int i, int s);
      return {8'(i), 24'(s)};
   endfunction

   // Source side: each requester sends numbered messages.
   int left[N];
   int seq[N];
   bit rand_mode = 0;

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         in_msg[i*W +: W] = pay(i, seq[i]);
         in_val[i] = (left[i] > 0) &&
                     (!rand_mode || $urandom_range(0, 3) != 0);
      end
   endtask

   task automatic step();
      logic [N-1:0] f;
      @(negedge clk);
      f = in_val & in_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (f[i]) begin
            seq[i]++;
            if (left[i] > 0) left[i]--;
         end
      drive();
   endtask

   logic [OW-1:0] seen[$];
   int            fcyc[$];

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("async_clear", {in_rdy, out_val, all_done, out_msg}, '0);
      for (int i = 0; i < N; i++) begin
         left[i] = 0;
         seq[i]  = 0;
      end
      drive();
      repeat (2) step();
      reset_n = 1'b1;
      seen.delete();
      fcyc.delete();
   endtask

   // Model: an owner holds a lease of B transfers; otherwise the
   // next winner is the first valid requester from m_start onward.
   int            m_who = -1;
   int            m_left = 0;
   int            m_start = 0;
   bit            m_live = 0;
   bit            m_oval = 0;
   bit            m_done = 0;
   logic [OW-1:0] m_omsg = '0;

   always @(negedge clk) begin
      int           g;
      logic [N-1:0] er;
      bit           can;
      bit           fire;
      bit           dn;
      cyc++;
      if (!reset_n) begin
         m_who = -1; m_left = 0; m_start = 0;
         m_live = 0; m_oval = 0; m_done = 0; m_omsg = '0;
         chk("reset_outs", {in_rdy, out_val, all_done, out_msg}, '0);
      end else begin
         can = m_live && (!m_oval || out_rdy);
         g = -1;
         if (m_who >= 0) begin
            if (in_val[m_who]) g = m_who;
         end else begin
            for (int k = 0; k < N; k++)
               if (g < 0 && in_val[(m_start + k) % N])
                  g = (m_start + k) % N;
         end
         er = '0;
         if (g >= 0 && can) er[g] = 1'b1;
         fire = (er != 0);
         chk("in_rdy", in_rdy, er);
         chk("out_val", out_val, m_oval);
         if (m_oval) chk("out_msg", out_msg, m_omsg);
         chk("all_done", all_done, m_done);
         if (out_val && out_rdy) begin
            seen.push_back(out_msg);
            fcyc.push_back(cyc);
         end
         dn = m_live && (&in_done) && !m_oval && !fire;
         if (fire) begin
            m_oval = 1;
            m_omsg = {IDW'(g), in_msg[g*W +: W]};
         end else if (m_oval && out_rdy) begin
            m_oval = 0;
         end
         m_done = dn;
         if (can) begin
            if (m_who >= 0 && !in_val[m_who]) begin
               m_start = (m_who + 1) % N;
               m_who = -1;
            end else if (fire) begin
               if (m_who < 0) begin
                  if (B == 1) m_start = (g + 1) % N;
                  else begin
                     m_who = g;
                     m_left = B - 1;
                  end
               end else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_start = (m_who + 1) % N;
                     m_who = -1;
                  end
               end
            end
         end
         m_live = 1;
      end
   end

   task automatic ids_are(string nm, int exp[]);
      chk({nm, "_cnt"}, 64'(seen.size() >= exp.size()), 64'(1));
      for (int j = 0; j < exp.size() && j < seen.size(); j++)
         chk(nm, 64'(seen[j][W +: IDW]), 64'(exp[j]));
   endtask

   initial begin
      #1;
      do_reset();

      // single requester, three messages, back to back
      out_rdy = 1'b1;
      left[0] = 3;
      drive();
      repeat (8) step();
      chk("single_cnt", 64'(seen.size()), 64'(3));
      ids_are("single_id", '{0, 0, 0});
      for (int j = 0; j < 3 && j < seen.size(); j++)
         chk("single_pay", 64'(seen[j][W-1:0]), 64'(pay(0, j)));
      if (fcyc.size() == 3)
         chk("single_gap", 64'(fcyc[2] - fcyc[0]), 64'(2));

      // all requesters valid: bursts of two, rotating
      do_reset();
      for (int i = 0; i < N; i++) left[i] = 50;
      drive();
      repeat (14) step();
      ids_are("rr_order", '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0});

      // owner 1 drops after one transfer, 2 takes over
      do_reset();
      left[1] = 1;
      left[2] = 3;
      drive();
      repeat (10) step();
      ids_are("drop_id", '{1, 2, 2});
      if (fcyc.size() >= 2)
         chk("drop_gap", 64'(fcyc[1] - fcyc[0]), 64'(2));

      // requesters 0 and 2 only: scan skips 1 and 3
      do_reset();
      left[0] = 10;
      left[2] = 10;
      drive();
      repeat (10) step();
      ids_are("skip_id", '{0, 0, 2, 2, 0, 0});

      // output stall for five cycles, then resume without loss
      do_reset();
      left[0] = 30;
      drive();
      repeat (4) step();
      out_rdy = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_rdy", 64'(in_rdy), 64'(0));
         @(posedge clk);
         #1;
      end
      out_rdy = 1'b1;
      repeat (10) step();
      chk("stall_cnt", 64'(seen.size() >= 10), 64'(1));
      for (int j = 0; j < seen.size(); j++)
         chk("stall_seq", 64'(seen[j][W-1:0]), 64'(pay(0, j)));

      // all_done waits for the output stage to drain
      do_reset();
      in_done = '1;
      out_rdy = 1'b0;
      left[0] = 1;
      drive();
      repeat (5) step();
      @(negedge clk);
      chk("done_full", 64'({out_val, all_done}), 64'(2));
      @(posedge clk);
      #1;
      out_rdy = 1'b1;
      repeat (2) step();
      @(negedge clk);
      chk("done_drain", 64'({out_val, all_done}), 64'(1));
      @(posedge clk);
      #1;
      in_done = '0;

      // reset mid-burst: next grant scans from requester 0
      do_reset();
      for (int i = 0; i < N; i++) left[i] = 10;
      drive();
      repeat (5) step();
      do_reset();
      for (int i = 0; i < N; i++) left[i] = 10;
      drive();
      repeat (4) step();
      ids_are("rst_scan", '{0});

      // random traffic, backpressure, done flags and resets
      do_reset();
      rand_mode = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         for (int i = 0; i < N; i++)
            if (left[i] < 5) left[i] = 1000;
         out_rdy = ($urandom_range(0, 3) != 0);
         in_done = ($urandom_range(0, 3) == 0) ?
                   N'($urandom) : '1;
         drive();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
